// File: rtl/sram_pkg.sv
// Shared definitions for the Blackice-II SRAM pin controller and the bridge
// that feeds it: state encoding, default geometry and the read latency the
// upstream skid buffer is sized for.
package sram_pkg;

   localparam int SRAM_ADDR_W     = 18;
   localparam int SRAM_DATA_W     = 16;
   localparam int SRAM_RD_LATENCY = 4;

   // Wide enough to hold WR_PULSE-1 for the largest legal WR_PULSE (7).
   localparam int SRAM_WR_CNT_W   = 3;
   localparam int SRAM_WR_PULSE_MIN = 1;
   localparam int SRAM_WR_PULSE_MAX = 7;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD0      = 3'd1,
      ST_RD1      = 3'd2,
      ST_RD2      = 3'd3,
      ST_WR_SETUP = 3'd4,
      ST_WR_PULSE = 3'd5,
      ST_WR_HOLD  = 3'd6
   } sram_state_t;

   // True while the chip output drivers are enabled for a read.
   function automatic logic is_rd_state(input sram_state_t s);
      return (s == ST_RD0) || (s == ST_RD1) || (s == ST_RD2);
   endfunction

   // True while the controller owns the data bus for a write.
   function automatic logic is_wr_state(input sram_state_t s);
      return (s == ST_WR_SETUP) || (s == ST_WR_PULSE) || (s == ST_WR_HOLD);
   endfunction

   // Keeps an out-of-range pulse length from wrapping the down-counter.
   function automatic int clamp_wr_pulse(input int p);
      if (p < SRAM_WR_PULSE_MIN) return SRAM_WR_PULSE_MIN;
      if (p > SRAM_WR_PULSE_MAX) return SRAM_WR_PULSE_MAX;
      return p;
   endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Pin-level controller for an asynchronous 256Kx16 SRAM. Accepts one request
// at a time over sram_req/sram_ready and turns it into a read or write cycle on
// the chip pins. Read data is strobed exactly SRAM_RD_LATENCY cycles after the
// accepting handshake. Every pin_* output is registered.
//
// Build option: define SRAM_CTRL_POWERDOWN_EN to drop chip enable while idle;
// otherwise pin_ce_n is held low whenever the block is out of reset.
//
// The pad tristate (sram_dq_pad) lives above this block and is driven from
// pin_dq_out / pin_dq_oe, returning pin_dq_in.
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int ADDR_W   = SRAM_ADDR_W,
   parameter int DATA_W   = SRAM_DATA_W,
   parameter int WR_PULSE = 2
) (
   input  logic              a_clk,
   input  logic              a_rst,

   input  logic              sram_req,
   output logic              sram_ready,
   input  logic              sram_rd,
   input  logic [ADDR_W-1:0] sram_addr,
   input  logic [1:0]        sram_be,
   input  logic [DATA_W-1:0] sram_wr_data,
   output logic              sram_rd_data_vld,
   output logic [DATA_W-1:0] sram_rd_data,

   output logic [ADDR_W-1:0] pin_addr,
   output logic [DATA_W-1:0] pin_dq_out,
   output logic              pin_dq_oe,
   input  logic [DATA_W-1:0] pin_dq_in,
   output logic              pin_ce_n,
   output logic              pin_oe_n,
   output logic              pin_we_n,
   output logic              pin_lb_n,
   output logic              pin_ub_n
);

   // Counter reload: the pulse state lasts (WR_LOAD + 1) cycles.
   localparam int WR_PULSE_C = clamp_wr_pulse(WR_PULSE);
   localparam logic [SRAM_WR_CNT_W-1:0] WR_LOAD = SRAM_WR_CNT_W'(WR_PULSE_C - 1);

   sram_state_t               state;
   sram_state_t               state_nxt;
   logic [SRAM_WR_CNT_W-1:0]  wr_cnt;
   logic [SRAM_WR_CNT_W-1:0]  wr_cnt_nxt;
   logic                      ce_n_nxt;

   // Handshake is purely combinational so the bridge sees acceptance in the
   // same cycle; it can only rise while a request is actually presented.
   assign sram_ready = (state == ST_IDLE) && sram_req;

   // Next-state and write pulse counter.
   always_comb begin
      state_nxt  = state;
      wr_cnt_nxt = wr_cnt;
      case (state)
         ST_IDLE: begin
            if (sram_req) begin
               state_nxt = sram_rd ? ST_RD0 : ST_WR_SETUP;
            end
         end
         ST_RD0:      state_nxt = ST_RD1;
         ST_RD1:      state_nxt = ST_RD2;
         ST_RD2:      state_nxt = ST_IDLE;
         ST_WR_SETUP: begin
            state_nxt  = ST_WR_PULSE;
            wr_cnt_nxt = WR_LOAD;
         end
         ST_WR_PULSE: begin
            if (wr_cnt == '0) begin
               state_nxt = ST_WR_HOLD;
            end else begin
               wr_cnt_nxt = wr_cnt - 1'b1;
            end
         end
         ST_WR_HOLD:  state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   // Chip enable policy: idle power-down, or always on once out of reset.
   always_comb begin
`ifdef SRAM_CTRL_POWERDOWN_EN
      ce_n_nxt = (state_nxt == ST_IDLE);
`else
      ce_n_nxt = 1'b0;
`endif
   end

   // State and counter register.
   always_ff @(posedge a_clk) begin
      if (a_rst) begin
         state  <= ST_IDLE;
         wr_cnt <= '0;
      end else begin
         state  <= state_nxt;
         wr_cnt <= wr_cnt_nxt;
      end
   end

   // Strobes are decoded from the next state so each registered pin lines up
   // with the state it belongs to; oe_n and dq_oe come from disjoint state
   // groups, so the chip and the pad can never drive the bus together.
   always_ff @(posedge a_clk) begin
      if (a_rst) begin
         pin_ce_n  <= 1'b1;
         pin_oe_n  <= 1'b1;
         pin_we_n  <= 1'b1;
         pin_dq_oe <= 1'b0;
      end else begin
         pin_ce_n  <= ce_n_nxt;
         pin_oe_n  <= !is_rd_state(state_nxt);
         pin_we_n  <= (state_nxt != ST_WR_PULSE);
         pin_dq_oe <= is_wr_state(state_nxt);
      end
   end

   // Address, byte lanes and write data are captured on the handshake and held
   // until the next one; reads always enable both lanes.
   always_ff @(posedge a_clk) begin
      if (a_rst) begin
         pin_addr   <= '0;
         pin_lb_n   <= 1'b1;
         pin_ub_n   <= 1'b1;
         pin_dq_out <= '0;
      end else if (sram_ready) begin
         pin_addr <= sram_addr;
         pin_lb_n <= sram_rd ? 1'b0 : ~sram_be[0];
         pin_ub_n <= sram_rd ? 1'b0 : ~sram_be[1];
         if (!sram_rd) begin
            pin_dq_out <= sram_wr_data;
         end
      end
   end

   // Read return: sample the pad on the edge leaving RD2 and strobe once.
   // A reset in RD0..RD2 sends the FSM to IDLE, so no strobe follows.
   always_ff @(posedge a_clk) begin
      if (a_rst) begin
         sram_rd_data_vld <= 1'b0;
         sram_rd_data     <= '0;
      end else begin
         sram_rd_data_vld <= (state == ST_RD2);
         if (state == ST_RD2) begin
            sram_rd_data <= pin_dq_in;
         end
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: a table of single transactions checked cycle by
// cycle against hand-derived pin timing, plus hand-written sequences for
// back-to-back reads, read-then-write turnaround, reset mid-read and idle
// chip-enable behaviour. Honours SRAM_CTRL_POWERDOWN_EN for pin_ce_n.
module tb_sram_ctrl;

   localparam int AW = 18;
   localparam int DW = 16;
   localparam int WP = 2;

   logic          a_clk = 1'b0;
   logic          a_rst;
   logic          sram_req;
   logic          sram_ready;
   logic          sram_rd;
   logic [AW-1:0] sram_addr;
   logic [1:0]    sram_be;
   logic [DW-1:0] sram_wr_data;
   logic          sram_rd_data_vld;
   logic [DW-1:0] sram_rd_data;
   logic [AW-1:0] pin_addr;
   logic [DW-1:0] pin_dq_out;
   logic          pin_dq_oe;
   logic [DW-1:0] pin_dq_in;
   logic          pin_ce_n, pin_oe_n, pin_we_n, pin_lb_n, pin_ub_n;
   logic [DW-1:0] pad_val;

   int total = 0;
   int bad   = 0;

   always #5 a_clk = ~a_clk;

   // Pad model: the chip only drives valid data while its output is enabled.
   assign pin_dq_in = pin_oe_n ? 16'hDEAD : pad_val;

   sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WR_PULSE(WP)) dut (
      .a_clk            (a_clk),
      .a_rst            (a_rst),
      .sram_req         (sram_req),
      .sram_ready       (sram_ready),
      .sram_rd          (sram_rd),
      .sram_addr        (sram_addr),
      .sram_be          (sram_be),
      .sram_wr_data     (sram_wr_data),
      .sram_rd_data_vld (sram_rd_data_vld),
      .sram_rd_data     (sram_rd_data),
      .pin_addr         (pin_addr),
      .pin_dq_out       (pin_dq_out),
      .pin_dq_oe        (pin_dq_oe),
      .pin_dq_in        (pin_dq_in),
      .pin_ce_n         (pin_ce_n),
      .pin_oe_n         (pin_oe_n),
      .pin_we_n         (pin_we_n),
      .pin_lb_n         (pin_lb_n),
      .pin_ub_n         (pin_ub_n)
   );

   typedef struct {
      logic          rd;
      logic [AW-1:0] addr;
      logic [1:0]    be;
      logic [DW-1:0] wdata;
      logic [DW-1:0] pad;
      logic          lb_n;
      logic          ub_n;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Expected chip enable for a cycle in which the FSM is (not) busy.
   function automatic logic ce_exp(input logic busy);
`ifdef SRAM_CTRL_POWERDOWN_EN
      return !busy;
`else
      return 1'b0;
`endif
   endfunction

   task automatic tick();
      @(posedge a_clk);
      #1;
   endtask

   task automatic samp();
      @(negedge a_clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{1'b1, 18'h01234, 2'b00, 16'h0000, 16'hBEEF, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 18'h3FFFF, 2'b01, 16'hA55A, 16'h0000, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 18'h00000, 2'b10, 16'h1234, 16'h0000, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 18'h3FFFF, 2'b00, 16'h0000, 16'h0001, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 18'h2AAAA, 2'b11, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 18'h15555, 2'b01, 16'h0000, 16'h8000, 1'b0, 1'b0};

      a_rst = 1'b1; sram_req = 1'b0; sram_rd = 1'b0; sram_addr = '0;
      sram_be = 2'b00; sram_wr_data = '0; pad_val = '0;

      // Reset state.
      tick(); tick(); samp();
      chk("rst ce_n",  pin_ce_n, 1);
      chk("rst oe_n",  pin_oe_n, 1);
      chk("rst we_n",  pin_we_n, 1);
      chk("rst lb_n",  pin_lb_n, 1);
      chk("rst ub_n",  pin_ub_n, 1);
      chk("rst dq_oe", pin_dq_oe, 0);
      chk("rst addr",  pin_addr, 0);
      chk("rst dq_out", pin_dq_out, 0);
      chk("rst vld",   sram_rd_data_vld, 0);
      chk("rst rdata", sram_rd_data, 0);
      tick(); a_rst = 1'b0;

      // Idle for 10 cycles: chip enable follows the build option.
      for (int k = 0; k < 10; k++) begin
         tick(); samp();
         chk($sformatf("idle ce_n k=%0d", k), pin_ce_n, ce_exp(1'b0));
         chk($sformatf("idle ready k=%0d", k), sram_ready, 0);
      end

      // Table of single transactions, each checked cycle by cycle.
      for (int v = 0; v < 6; v++) begin
         int lat;
         lat = vecs[v].rd ? 4 : 3 + WP;
         tick();
         sram_req = 1'b1; sram_rd = vecs[v].rd; sram_addr = vecs[v].addr;
         sram_be = vecs[v].be; sram_wr_data = vecs[v].wdata; pad_val = vecs[v].pad;
         samp();
         chk($sformatf("v%0d ready", v), sram_ready, 1);
         for (int k = 1; k <= lat; k++) begin
            logic rd;
            rd = vecs[v].rd;
            tick(); sram_req = 1'b0;
            samp();
            chk($sformatf("v%0d k%0d oe_n", v, k), pin_oe_n, (rd && k <= 3) ? 0 : 1);
            chk($sformatf("v%0d k%0d vld", v, k), sram_rd_data_vld, (rd && k == 4) ? 1 : 0);
            chk($sformatf("v%0d k%0d dq_oe", v, k), pin_dq_oe, (!rd && k <= 2 + WP) ? 1 : 0);
            chk($sformatf("v%0d k%0d we_n", v, k), pin_we_n, (!rd && k >= 2 && k <= 1 + WP) ? 0 : 1);
            chk($sformatf("v%0d k%0d ce_n", v, k), pin_ce_n, ce_exp(k < lat));
            chk($sformatf("v%0d k%0d addr", v, k), pin_addr, vecs[v].addr);
            chk($sformatf("v%0d k%0d lb_n", v, k), pin_lb_n, vecs[v].lb_n);
            chk($sformatf("v%0d k%0d ub_n", v, k), pin_ub_n, vecs[v].ub_n);
            if (!rd && k < lat)
               chk($sformatf("v%0d k%0d dq_out", v, k), pin_dq_out, vecs[v].wdata);
            if (rd && k == 4)
               chk($sformatf("v%0d rdata", v), sram_rd_data, vecs[v].pad);
         end
      end

      // Back-to-back reads with the request held: handshakes every 4 cycles.
      for (int k = 0; k <= 12; k++) begin
         tick();
         sram_req = (k <= 8); sram_rd = 1'b1; sram_addr = 18'h00100 + 18'(k);
         pad_val = 16'h0F00 + 16'(k);
         samp();
         chk($sformatf("b2b k%0d ready", k), sram_ready, (k % 4 == 0 && k <= 8) ? 1 : 0);
         chk($sformatf("b2b k%0d vld", k), sram_rd_data_vld, (k % 4 == 0 && k >= 4) ? 1 : 0);
         if (k % 4 == 0 && k >= 4)
            chk($sformatf("b2b k%0d rdata", k), sram_rd_data, 16'h0F00 + 16'(k - 1));
      end

      // Read then two writes: turnaround on the strobe cycle, no bus overlap.
      for (int k = 0; k <= 15; k++) begin
         logic dq_exp, we_exp;
         tick();
         sram_req = (k == 0) || (k >= 4 && k <= 9);
         sram_rd = (k == 0);
         sram_addr = (k == 0) ? 18'h00040 : 18'h00ABC;
         sram_be = 2'b11; sram_wr_data = 16'h5A5A; pad_val = 16'hC3C3;
         samp();
         dq_exp = (k >= 5 && k <= 8) || (k >= 10 && k <= 13);
         we_exp = !(k == 6 || k == 7 || k == 11 || k == 12);
         chk($sformatf("rw k%0d ready", k), sram_ready, (k == 0 || k == 4 || k == 9) ? 1 : 0);
         chk($sformatf("rw k%0d vld", k), sram_rd_data_vld, (k == 4) ? 1 : 0);
         chk($sformatf("rw k%0d dq_oe", k), pin_dq_oe, dq_exp);
         chk($sformatf("rw k%0d we_n", k), pin_we_n, we_exp);
         chk($sformatf("rw k%0d oe_n", k), pin_oe_n, (k >= 1 && k <= 3) ? 0 : 1);
         chk($sformatf("rw k%0d bus overlap", k), pin_dq_oe & ~pin_oe_n, 0);
         if (k == 4) chk("rw rdata", sram_rd_data, 16'hC3C3);
      end

      // Reset asserted for one cycle while the read sits in RD1.
      for (int k = 0; k <= 7; k++) begin
         tick();
         sram_req = (k == 0); sram_rd = 1'b1; sram_addr = 18'h02222;
         pad_val = 16'h7777;
         a_rst = (k == 2);
         samp();
         if (k == 2) chk("abort k2 oe_n", pin_oe_n, 0);
         if (k == 3) begin
            chk("abort ce_n",  pin_ce_n, 1);
            chk("abort oe_n",  pin_oe_n, 1);
            chk("abort we_n",  pin_we_n, 1);
            chk("abort lb_n",  pin_lb_n, 1);
            chk("abort ub_n",  pin_ub_n, 1);
            chk("abort dq_oe", pin_dq_oe, 0);
            chk("abort addr",  pin_addr, 0);
         end
         if (k >= 3) begin
            chk($sformatf("abort k%0d vld", k), sram_rd_data_vld, 0);
            chk($sformatf("abort k%0d oe_n", k), pin_oe_n, 1);
         end
         if (k >= 4) chk($sformatf("abort k%0d ce_n", k), pin_ce_n, ce_exp(1'b0));
         if (k == 7) chk("abort rdata", sram_rd_data, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
